// File: rtl/poly_voice_mixer_pkg.sv
// Shared types and helpers for the polyphonic voice mixer: FSM state,
// width helpers and the signed saturation function (also used by chords).
package poly_voice_mixer_pkg;

  localparam int unsigned SAT_CALC_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } mix_state_e;

  function automatic int unsigned vidx_w(input int unsigned num_voices);
    return (num_voices <= 1) ? 1 : $clog2(num_voices);
  endfunction

  function automatic int unsigned acc_w(input int unsigned sample_w, input int unsigned num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of width w (w <= 32).
  function automatic logic signed [SAT_CALC_W-1:0] sat_to(input logic signed [SAT_CALC_W-1:0] v,
                                                          input int unsigned w);
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/poly_voice_mixer_if.sv
// Request/response link between the mixer and the shared per-voice sample source.
interface poly_voice_mixer_if #(
  parameter int unsigned VIDX_W       = 2,
  parameter int unsigned NOTE_WIDTH   = 6,
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic                           voice_req;
  logic [VIDX_W-1:0]              voice_idx;
  logic [NOTE_WIDTH-1:0]          voice_note;
  logic signed [SAMPLE_WIDTH-1:0] voice_sample;
  logic                           voice_sample_valid;

  modport master (
    output voice_req, voice_idx, voice_note,
    input  voice_sample, voice_sample_valid
  );

  modport slave (
    input  voice_req, voice_idx, voice_note,
    output voice_sample, voice_sample_valid
  );
endinterface

// File: rtl/poly_voice_mixer_voice_slot.sv
// One note slot: holds note and remaining beats; a load always beats a
// simultaneous decrement.
module poly_voice_mixer_voice_slot #(
  parameter int unsigned NOTE_WIDTH = 6,
  parameter int unsigned DUR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NOTE_WIDTH-1:0] note_in,
  input  logic [DUR_WIDTH-1:0]  dur_in,
  input  logic                  tick,
  output logic [NOTE_WIDTH-1:0] note,
  output logic                  active
);

  logic [DUR_WIDTH-1:0] dur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note   <= '0;
      dur    <= '0;
      active <= 1'b0;
    end else if (load) begin
      note   <= note_in;
      dur    <= dur_in;
      active <= |dur_in;
    end else if (tick && active) begin
      dur <= dur - DUR_WIDTH'(1);
      if (dur == DUR_WIDTH'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/poly_voice_mixer.sv
// N-voice mixer: per frame, walks the active slots, fetches one sample per
// voice from a shared source and emits the saturated sum.
module poly_voice_mixer
  import poly_voice_mixer_pkg::*;
#(
  parameter  int unsigned NUM_VOICES   = 3,
  parameter  int unsigned SAMPLE_WIDTH = 16,
  parameter  int unsigned NOTE_WIDTH   = 6,
  parameter  int unsigned DUR_WIDTH    = 6,
  localparam int unsigned VIDX_W       = vidx_w(NUM_VOICES),
  localparam int unsigned ACC_W        = acc_w(SAMPLE_WIDTH, NUM_VOICES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_enable,
  input  logic                           load_voice,
  input  logic [VIDX_W-1:0]              load_index,
  input  logic [NOTE_WIDTH-1:0]          note_to_load,
  input  logic [DUR_WIDTH-1:0]           duration_to_load,
  input  logic                           beat,
  input  logic                           generate_next_sample,
  poly_voice_mixer_if.master             src,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           new_sample_ready,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic                           all_voices_done
);

  localparam int unsigned CNT_W = $clog2(NUM_VOICES + 1);
  localparam int unsigned NSLOT = 1 << VIDX_W;

  // Slot views padded to a power of two so any VIDX_W index is in range.
  logic [NSLOT-1:0]      active_pad;
  logic [NOTE_WIDTH-1:0] note_pad [NSLOT];
  logic                  slot_tick;

  assign slot_tick = beat & play_enable;

  for (genvar v = 0; v < NSLOT; v++) begin : g_slot
    if (v < NUM_VOICES) begin : g_real
      poly_voice_mixer_voice_slot #(
        .NOTE_WIDTH(NOTE_WIDTH),
        .DUR_WIDTH (DUR_WIDTH)
      ) u_slot (
        .clk    (clk),
        .rst    (reset),
        .load   (load_voice && (load_index == VIDX_W'(v))),
        .note_in(note_to_load),
        .dur_in (duration_to_load),
        .tick   (slot_tick),
        .note   (note_pad[v]),
        .active (active_pad[v])
      );
    end else begin : g_pad
      assign note_pad[v]   = '0;
      assign active_pad[v] = 1'b0;
    end
  end

  assign voice_active    = active_pad[NUM_VOICES-1:0];
  assign all_voices_done = ~|voice_active;

  mix_state_e               state;
  logic [CNT_W-1:0]         vi;
  logic signed [ACC_W-1:0]  acc;
  logic [VIDX_W-1:0]        vi_sel;

  assign vi_sel = vi[VIDX_W-1:0];

  // Frame sequencer; sample_out and new_sample_ready update on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      vi               <= '0;
      acc              <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
      src.voice_req    <= 1'b0;
      src.voice_idx    <= '0;
      src.voice_note   <= '0;
    end else begin
      new_sample_ready <= 1'b0;
      src.voice_req    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (generate_next_sample) begin
            acc   <= '0;
            vi    <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (vi == CNT_W'(NUM_VOICES)) begin
            sample_out       <= SAMPLE_WIDTH'(sat_to(SAT_CALC_W'(acc), SAMPLE_WIDTH));
            new_sample_ready <= 1'b1;
            state            <= ST_DONE;
          end else if (active_pad[vi_sel] && play_enable) begin
            src.voice_req  <= 1'b1;
            src.voice_idx  <= vi_sel;
            src.voice_note <= note_pad[vi_sel];
            state          <= ST_REQ;
          end else begin
            vi <= vi + CNT_W'(1);
          end
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          if (src.voice_sample_valid) begin
            acc   <= acc + ACC_W'(src.voice_sample);
            vi    <= vi + CNT_W'(1);
            state <= ST_SCAN;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
